// File: rtl/l1_cache_pkg.sv
// Shared LC-3b types for the L1 cache: line/tag/index/offset/mask aliases,
// the cache FSM state encoding and the byte-merge helper.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_datbus;

   typedef logic [8:0]   lc3b_c_tag;
   typedef logic [2:0]   lc3b_c_index;
   typedef logic [3:0]   lc3b_c_offset;
   typedef lc3b_datbus   lc3b_c_line;
   typedef logic [15:0]  lc3b_c_mask;

   typedef enum logic [1:0] {
      C_IDLE      = 2'd0,
      C_WRITEBACK = 2'd1,
      C_ALLOCATE  = 2'd2
   } l1_state_e;

   // Overlay enabled bytes of a pre-positioned write line onto a stored line.
   function automatic lc3b_c_line byte_merge(input lc3b_c_line line,
                                             input lc3b_c_line wdata,
                                             input lc3b_c_mask mask);
      lc3b_c_line result;
      result = line;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) result[8*i +: 8] = wdata[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Per-set storage array: combinational read, synchronous write on load.
// CLEARABLE instances (valid/dirty/LRU) clear asynchronously on rst.
import lc3b_types::*;

module cache_array #(
   parameter int WIDTH     = 1,
   parameter int NUM_SETS  = 8,
   parameter int IDX_W     = $clog2(NUM_SETS),
   parameter bit CLEARABLE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [IDX_W-1:0] index,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [NUM_SETS];

   generate
      if (CLEARABLE) begin : g_clear
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
            end else if (load) begin
               mem[index] <= din;
            end
         end
      end else begin : g_noclear
         // Tag and data contents survive reset; only their valid bits matter.
         logic unused_rst;
         assign unused_rst = rst;
         always_ff @(posedge clk) begin
            if (load) mem[index] <= din;
         end
      end
   endgenerate

   assign dout = mem[index];

endmodule

// File: rtl/l1_cache.sv
// Two-way set-associative write-back/write-allocate L1 cache for LC-3b.
// Define L1_CACHE_STATS_EN to add the hit_count/miss_count statistics ports.
//
// state       | meaning
// C_IDLE      | serve hits in the request cycle, pick a victim on a miss
// C_WRITEBACK | write the dirty victim line to memory
// C_ALLOCATE  | fetch the requested line into the victim way
import lc3b_types::*;

module l1_cache #(
   parameter int NUM_SETS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [15:0]  mem_byte_enable,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
`ifdef L1_CACHE_STATS_EN
   ,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
`endif
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 12 - IDX_W;

   l1_state_e state, next_state;

   logic             req, is_write;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_index, arr_index;
   logic             unused_offset;

   logic [TAG_W-1:0] miss_tag;
   logic [IDX_W-1:0] miss_index;
   logic             miss_way, miss_go;

   logic [TAG_W-1:0] tag_q   [2];
   lc3b_c_line       data_q  [2];
   logic             valid_q [2];
   logic             dirty_q [2];
   logic             lru_q;

   logic [1:0]       tag_ld, data_ld, valid_ld, dirty_ld;
   logic             lru_ld, lru_din, dirty_din;
   lc3b_c_line       data_din;

   logic [1:0]       hit_vec;
   logic             hit, hit_way, victim;
   lc3b_c_line       hit_line;

   assign req           = mem_read | mem_write;
   assign is_write      = mem_write;
   assign req_tag       = mem_address[15:4+IDX_W];
   assign req_index     = mem_address[4+IDX_W-1:4];
   assign unused_offset = ^mem_address[3:0];

   // During a miss the arrays are addressed by the latched set, so a CPU that
   // illegally drops or changes its request cannot corrupt the fill.
   assign arr_index = (state == C_IDLE) ? req_index : miss_index;

   generate
      for (genvar w = 0; w < 2; w++) begin : g_way
         cache_array #(.WIDTH(TAG_W), .NUM_SETS(NUM_SETS), .CLEARABLE(1'b0)) u_tag (
            .clk(clk), .rst(rst), .load(tag_ld[w]), .index(arr_index),
            .din(miss_tag), .dout(tag_q[w]));
         cache_array #(.WIDTH(128), .NUM_SETS(NUM_SETS), .CLEARABLE(1'b0)) u_data (
            .clk(clk), .rst(rst), .load(data_ld[w]), .index(arr_index),
            .din(data_din), .dout(data_q[w]));
         cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS), .CLEARABLE(1'b1)) u_valid (
            .clk(clk), .rst(rst), .load(valid_ld[w]), .index(arr_index),
            .din(1'b1), .dout(valid_q[w]));
         cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS), .CLEARABLE(1'b1)) u_dirty (
            .clk(clk), .rst(rst), .load(dirty_ld[w]), .index(arr_index),
            .din(dirty_din), .dout(dirty_q[w]));
         assign hit_vec[w] = valid_q[w] && (tag_q[w] == req_tag);
      end
   endgenerate

   cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS), .CLEARABLE(1'b1)) u_lru (
      .clk(clk), .rst(rst), .load(lru_ld), .index(arr_index),
      .din(lru_din), .dout(lru_q));

   assign hit      = |hit_vec;
   assign hit_way  = ~hit_vec[0];
   assign hit_line = data_q[hit_way];
   assign victim   = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= C_IDLE;
         miss_way   <= 1'b0;
         miss_index <= '0;
         miss_tag   <= '0;
      end else begin
         state <= next_state;
         if (miss_go) begin
            miss_way   <= victim;
            miss_index <= req_index;
            miss_tag   <= req_tag;
         end
      end
   end

   always_comb begin
      next_state   = state;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      miss_go      = 1'b0;
      tag_ld       = '0;
      data_ld      = '0;
      valid_ld     = '0;
      dirty_ld     = '0;
      lru_ld       = 1'b0;
      lru_din      = 1'b0;
      dirty_din    = 1'b0;
      data_din     = '0;
      unique case (state)
         C_IDLE: begin
            if (req && hit) begin
               mem_resp  = 1'b1;
               mem_rdata = hit_line;
               lru_ld    = 1'b1;
               lru_din   = ~hit_way;
               if (is_write) begin
                  data_ld[hit_way]  = 1'b1;
                  data_din          = byte_merge(hit_line, mem_wdata, mem_byte_enable);
                  dirty_ld[hit_way] = 1'b1;
                  dirty_din         = 1'b1;
               end
            end else if (req) begin
               miss_go    = 1'b1;
               next_state = (valid_q[victim] && dirty_q[victim]) ? C_WRITEBACK : C_ALLOCATE;
            end
         end
         C_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[miss_way], miss_index, 4'b0000};
            pmem_wdata   = data_q[miss_way];
            if (pmem_resp) next_state = C_ALLOCATE;
         end
         C_ALLOCATE: begin
            pmem_read    = 1'b1;
            pmem_address = {miss_tag, miss_index, 4'b0000};
            if (pmem_resp) begin
               data_ld[miss_way]  = 1'b1;
               data_din           = pmem_rdata;
               tag_ld[miss_way]   = 1'b1;
               valid_ld[miss_way] = 1'b1;
               dirty_ld[miss_way] = 1'b1;
               dirty_din          = 1'b0;
               next_state         = C_IDLE;
            end
         end
         default: next_state = C_IDLE;
      endcase
   end

`ifdef L1_CACHE_STATS_EN
   // The hit that completes a filled request belongs to that miss, not to hits.
   logic miss_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count    <= '0;
         miss_count   <= '0;
         miss_pending <= 1'b0;
      end else begin
         if (miss_go) begin
            miss_count   <= miss_count + 16'd1;
            miss_pending <= 1'b1;
         end
         if (mem_resp) begin
            if (!miss_pending) hit_count <= hit_count + 16'd1;
            miss_pending <= 1'b0;
         end else if (state == C_IDLE && !req) begin
            miss_pending <= 1'b0;
         end
      end
   end
`endif

endmodule
